// File: rtl/ehl_gpio_core.sv
// GPIO controller core: register bank with atomic ops, 2-FF input sync, per-pin glitch filter,
// edge/level interrupt flags. Define EHL_GPIO_BOTH_EDGES_EN to add the GBER both-edges register.
module ehl_gpio_core #(
  parameter int          WIDTH    = 32,
  parameter int          FLT_W    = 4,
  parameter logic [31:0] RST_GDOR = '0,
  parameter logic [31:0] RST_GOER = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr,
  input  logic             rd,
  input  logic [5:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [3:0] IDX_GDOR = 4'd0, IDX_GOER = 4'd1, IDX_GPER = 4'd3, IDX_GPTR = 4'd4,
                         IDX_GIER = 4'd5, IDX_GISR = 4'd6, IDX_GIFR = 4'd7, IDX_GDIR = 4'd8,
                         IDX_GFTR = 4'd9, IDX_GBER = 4'd11;

  // wr/rd are single-cycle strobes with no back-pressure: a write commits on the edge that
  // samples it; a read captures the pre-write register value and presents it with rvalid
  // for exactly one cycle after the rd edge.
  logic [3:0]       idx;
  logic [1:0]       op;
  logic [31:0]      wd32, rmux;
  logic [WIDTH-1:0] gdor, goer, gper, gptr, gier, gisr, gifr, gber_v;
  logic [FLT_W-1:0] gftr;
  logic [WIDTH-1:0] sync1, sync2, flt_q, filtered, prev, event_v, w1c;
  logic [FLT_W-1:0] cnt [WIDTH];
  logic             flt_on;

  assign idx      = addr[5:2];
  assign op       = addr[1:0];
  assign wd32     = 32'(wdata);
  assign gpio_out = gdor;
  assign gpio_oe  = goer;

  function automatic logic [31:0] apply_op(input logic [31:0] cur, input logic [31:0] wd,
                                           input logic [1:0] o);
    case (o)
      2'd0:    return wd;
      2'd1:    return cur | wd;
      2'd2:    return cur & ~wd;
      default: return cur ^ wd;
    endcase
  endfunction

`ifdef EHL_GPIO_BOTH_EDGES_EN
  logic [WIDTH-1:0] gber;
  assign gber_v = gber;
`else
  assign gber_v = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gdor <= RST_GDOR[WIDTH-1:0];
      goer <= RST_GOER[WIDTH-1:0];
      gper <= '0;
      gptr <= '0;
      gier <= '0;
      gisr <= '0;
      gftr <= '0;
`ifdef EHL_GPIO_BOTH_EDGES_EN
      gber <= '0;
`endif
    end else if (wr) begin
      case (idx)
        IDX_GDOR: gdor <= WIDTH'(apply_op(32'(gdor), wd32, op));
        IDX_GOER: goer <= WIDTH'(apply_op(32'(goer), wd32, op));
        IDX_GPER: gper <= WIDTH'(apply_op(32'(gper), wd32, op));
        IDX_GPTR: gptr <= WIDTH'(apply_op(32'(gptr), wd32, op));
        IDX_GIER: gier <= WIDTH'(apply_op(32'(gier), wd32, op));
        IDX_GISR: gisr <= WIDTH'(apply_op(32'(gisr), wd32, op));
        IDX_GFTR: gftr <= FLT_W'(apply_op(32'(gftr), wd32, op));
`ifdef EHL_GPIO_BOTH_EDGES_EN
        IDX_GBER: gber <= WIDTH'(apply_op(32'(gber), wd32, op));
`endif
        default: ;
      endcase
    end
  end

  // Filter is bypassed per pin when disabled or when the shared threshold is zero.
  always_comb begin
    flt_on = (gftr != '0);
    for (int i = 0; i < WIDTH; i++) begin
      filtered[i] = (gper[i] && flt_on) ? flt_q[i] : sync2[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      flt_q <= '0;
      prev  <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      prev  <= filtered;
      for (int i = 0; i < WIDTH; i++) begin
        if (gper[i] && flt_on) begin
          if (sync2[i] != flt_q[i]) begin
            if (({1'b0, cnt[i]} + 1'b1) >= {1'b0, gftr}) begin
              flt_q[i] <= ~flt_q[i];
              cnt[i]   <= '0;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end else begin
            cnt[i] <= '0;
          end
        end else begin
          // Track the sync value so enabling the filter never causes a jump.
          flt_q[i] <= sync2[i];
          cnt[i]   <= '0;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      if (gisr[i]) begin
        if (gber_v[i])    event_v[i] = filtered[i] ^ prev[i];
        else if (gptr[i]) event_v[i] = filtered[i] & ~prev[i];
        else              event_v[i] = ~filtered[i] & prev[i];
      end else begin
        event_v[i] = (filtered[i] == gptr[i]);
      end
    end
    w1c = (wr && idx == IDX_GIFR && op == 2'd2) ? wdata : '0;
  end

  // Hardware set is OR-ed after the W1C mask so a coincident event wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gifr <= '0;
      irq  <= 1'b0;
    end else begin
      gifr <= (gifr & ~w1c) | event_v;
      irq  <= |(gifr & gier);
    end
  end

  always_comb begin
    rmux = '0;
    if (op == 2'd0) begin
      case (idx)
        IDX_GDOR: rmux = 32'(gdor);
        IDX_GOER: rmux = 32'(goer);
        IDX_GPER: rmux = 32'(gper);
        IDX_GPTR: rmux = 32'(gptr);
        IDX_GIER: rmux = 32'(gier);
        IDX_GISR: rmux = 32'(gisr);
        IDX_GIFR: rmux = 32'(gifr);
        IDX_GDIR: rmux = 32'(filtered);
        IDX_GFTR: rmux = 32'(gftr);
        IDX_GBER: rmux = 32'(gber_v);
        default:  rmux = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else if (rd) begin
      rdata  <= rmux[WIDTH-1:0];
      rvalid <= 1'b1;
    end else begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ehl_gpio_core.sv
// Directed, table-driven bench for ehl_gpio_core: each vector is one clock cycle of bus/pad
// stimulus plus one expected-value check taken 1 time unit after the rising edge.
module tb_ehl_gpio_core;

  localparam int W = 32;
  localparam logic [2:0] C_NONE = 3'd0, C_RD = 3'd1, C_OUT = 3'd2, C_OE = 3'd3,
                         C_IRQ = 3'd4, C_RV = 3'd5;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] gin;
    logic [2:0]  chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         wr = 1'b0, rd = 1'b0;
  logic [5:0]   addr = '0;
  logic [W-1:0] wdata = '0, gpio_in = '0;
  logic [W-1:0] rdata, gpio_out, gpio_oe;
  logic         rvalid, irq;

  int n_pass = 0;
  int n_total = 0;
  vec_t vq[$];

  ehl_gpio_core dut (
    .clk(clk), .reset_n(reset_n), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic w, input logic r, input logic [5:0] a,
                              input logic [31:0] d, input logic [31:0] g,
                              input logic [2:0] c, input logic [31:0] e, input string n);
    vec_t v;
    v.wr = w; v.rd = r; v.addr = a; v.wdata = d; v.gin = g; v.chk = c; v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic run_vec(input vec_t v);
    wr = v.wr; rd = v.rd; addr = v.addr; wdata = v.wdata; gpio_in = v.gin;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0;
    case (v.chk)
      C_RD: begin
        check({v.name, "_rvalid"}, 32'(rvalid), 32'd1);
        check(v.name, rdata, v.exp);
      end
      C_OUT: check(v.name, gpio_out, v.exp);
      C_OE:  check(v.name, gpio_oe, v.exp);
      C_IRQ: check(v.name, 32'(irq), v.exp);
      C_RV:  check(v.name, 32'(rvalid), v.exp);
      default: ;
    endcase
  endtask

  task automatic idle(input logic [31:0] g, input int n);
    for (int k = 0; k < n; k++) run_vec(mk(0, 0, 6'h00, 0, g, C_NONE, 0, ""));
  endtask

  initial begin
    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_gpio_out", gpio_out, 32'h0);
    check("rst_gpio_oe", gpio_oe, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;

    // GIFR read first: level-low events with reset GPTR=0 set flags on the first edge.
    vq.push_back(mk(0, 1, 6'h1C, 0, 0, C_RD, 32'h0, "rst_gifr"));
    vq.push_back(mk(0, 1, 6'h00, 0, 0, C_RD, 32'h0, "rst_gdor"));
    vq.push_back(mk(0, 1, 6'h04, 0, 0, C_RD, 32'h0, "rst_goer"));
    vq.push_back(mk(0, 1, 6'h20, 0, 0, C_RD, 32'h0, "rst_gdir"));
    vq.push_back(mk(0, 0, 6'h00, 0, 0, C_RV, 32'h0, "idle_rvalid"));
    vq.push_back(mk(0, 0, 6'h00, 0, 0, C_OE, 32'h0, "post_rst_oe"));
    vq.push_back(mk(0, 0, 6'h00, 0, 0, C_IRQ, 32'h0, "post_rst_irq"));
    // Atomic ops on GDOR.
    vq.push_back(mk(1, 0, 6'h00, 32'hF0, 0, C_OUT, 32'hF0, "gdor_wr"));
    vq.push_back(mk(1, 0, 6'h01, 32'h0F, 0, C_OUT, 32'hFF, "gdor_set"));
    vq.push_back(mk(1, 0, 6'h02, 32'h30, 0, C_OUT, 32'hCF, "gdor_clr"));
    vq.push_back(mk(1, 0, 6'h03, 32'h101, 0, C_OUT, 32'h1CE, "gdor_inv"));
    vq.push_back(mk(1, 0, 6'h04, 32'hA5, 0, C_OE, 32'hA5, "goer_wr"));
    vq.push_back(mk(0, 1, 6'h05, 0, 0, C_RD, 32'h0, "rd_op_nonzero"));
    vq.push_back(mk(0, 1, 6'h00, 0, 0, C_RD, 32'h1CE, "rd_gdor"));
    vq.push_back(mk(1, 1, 6'h00, 32'h55, 0, C_RD, 32'h1CE, "rd_wr_same"));
    vq.push_back(mk(0, 0, 6'h00, 0, 0, C_OUT, 32'h55, "gdor_after_rdwr"));
    // Writes to reserved / read-only / unused indices do nothing.
    vq.push_back(mk(1, 0, 6'h28, 32'hFFFF, 0, C_OUT, 32'h55, "wr_reserved"));
    vq.push_back(mk(1, 0, 6'h20, 32'hFFFF, 0, C_NONE, 0, ""));
    vq.push_back(mk(1, 0, 6'h08, 32'hFFFF, 0, C_NONE, 0, ""));
    vq.push_back(mk(0, 1, 6'h28, 0, 0, C_RD, 32'h0, "rd_reserved"));
    vq.push_back(mk(0, 1, 6'h08, 0, 0, C_RD, 32'h0, "rd_gafr"));
    vq.push_back(mk(0, 1, 6'h20, 0, 0, C_RD, 32'h0, "rd_gdir_after_wr"));
    // Polarity high everywhere, then clear the reset-time level flags.
    vq.push_back(mk(1, 0, 6'h10, 32'hFFFF_FFFF, 0, C_NONE, 0, ""));
    vq.push_back(mk(1, 0, 6'h1E, 32'hFFFF_FFFF, 0, C_NONE, 0, ""));
    vq.push_back(mk(0, 1, 6'h1C, 0, 0, C_RD, 32'h0, "gifr_cleared"));
    vq.push_back(mk(0, 1, 6'h10, 0, 0, C_RD, 32'hFFFF_FFFF, "rd_gptr"));
    vq.push_back(mk(1, 0, 6'h1C, 32'hFFFF, 0, C_NONE, 0, ""));
    vq.push_back(mk(1, 0, 6'h1D, 32'hFFFF, 0, C_NONE, 0, ""));
    vq.push_back(mk(0, 1, 6'h1C, 0, 0, C_RD, 32'h0, "gifr_wr_set_ignored"));
    // Pin 3 rising-edge interrupt.
    vq.push_back(mk(1, 0, 6'h19, 32'h8, 0, C_NONE, 0, ""));
    vq.push_back(mk(1, 0, 6'h15, 32'h8, 0, C_NONE, 0, ""));
    vq.push_back(mk(0, 0, 6'h00, 0, 32'h8, C_NONE, 0, ""));
    vq.push_back(mk(0, 0, 6'h00, 0, 32'h8, C_NONE, 0, ""));
    vq.push_back(mk(0, 0, 6'h00, 0, 32'h8, C_IRQ, 32'h0, "irq_not_yet"));
    vq.push_back(mk(0, 1, 6'h1C, 0, 32'h8, C_RD, 32'h8, "gifr_edge3"));
    vq.push_back(mk(0, 0, 6'h00, 0, 32'h8, C_IRQ, 32'h1, "irq_set"));
    vq.push_back(mk(1, 0, 6'h1E, 32'h8, 32'h8, C_IRQ, 32'h1, "irq_hold_at_w1c"));
    vq.push_back(mk(0, 0, 6'h00, 0, 32'h8, C_IRQ, 32'h0, "irq_cleared"));
    for (int k = 0; k < 4; k++) vq.push_back(mk(0, 0, 6'h00, 0, 0, C_NONE, 0, ""));
    vq.push_back(mk(0, 1, 6'h1C, 0, 0, C_RD, 32'h0, "no_fall_flag"));
    vq.push_back(mk(0, 0, 6'h00, 0, 0, C_IRQ, 32'h0, "irq_after_fall"));
    // Pin 5 level-low: W1C coinciding with an active event loses.
    vq.push_back(mk(1, 0, 6'h12, 32'h20, 0, C_NONE, 0, ""));
    vq.push_back(mk(0, 0, 6'h00, 0, 0, C_NONE, 0, ""));
    vq.push_back(mk(1, 0, 6'h1E, 32'h20, 0, C_NONE, 0, ""));
    vq.push_back(mk(0, 1, 6'h1C, 0, 0, C_RD, 32'h20, "level_set_wins"));
    vq.push_back(mk(1, 0, 6'h11, 32'h20, 0, C_NONE, 0, ""));
    vq.push_back(mk(1, 0, 6'h1E, 32'h20, 0, C_NONE, 0, ""));
    vq.push_back(mk(0, 1, 6'h1C, 0, 0, C_RD, 32'h0, "level_cleared"));
    // Pin 0 glitch filter, threshold 4.
    vq.push_back(mk(1, 0, 6'h0D, 32'h1, 0, C_NONE, 0, ""));
    vq.push_back(mk(1, 0, 6'h24, 32'h4, 0, C_NONE, 0, ""));
    vq.push_back(mk(0, 1, 6'h24, 0, 0, C_RD, 32'h4, "rd_gftr"));
    for (int k = 0; k < 3; k++) vq.push_back(mk(0, 1, 6'h20, 0, 32'h1, C_RD, 32'h0, "flt_short_hi"));
    for (int k = 0; k < 6; k++) vq.push_back(mk(0, 1, 6'h20, 0, 32'h0, C_RD, 32'h0, "flt_short_lo"));
    for (int k = 0; k < 6; k++) vq.push_back(mk(0, 1, 6'h20, 0, 32'h1, C_RD, 32'h0, "flt_long_wait"));
    vq.push_back(mk(0, 1, 6'h20, 0, 32'h0, C_RD, 32'h1, "flt_long_hit"));

    foreach (vq[i]) run_vec(vq[i]);

`ifdef EHL_GPIO_BOTH_EDGES_EN
    // Pin 2 both-edges: GPTR[2]=1, yet the falling edge must still flag.
    run_vec(mk(1, 0, 6'h19, 32'h4, 0, C_NONE, 0, ""));
    run_vec(mk(1, 0, 6'h2D, 32'h4, 0, C_NONE, 0, ""));
    run_vec(mk(0, 1, 6'h2C, 0, 0, C_RD, 32'h4, "rd_gber"));
    idle(32'h4, 4);
    run_vec(mk(1, 0, 6'h1E, 32'h4, 32'h4, C_NONE, 0, ""));
    run_vec(mk(0, 1, 6'h1C, 0, 32'h4, C_NONE, 0, ""));
    check("gber_after_w1c", 32'(rdata[2]), 32'h0);
    idle(32'h0, 4);
    run_vec(mk(0, 1, 6'h1C, 0, 0, C_NONE, 0, ""));
    check("gber_fall_flag", 32'(rdata[2]), 32'h1);
`else
    run_vec(mk(1, 0, 6'h2C, 32'hFFFF, 0, C_NONE, 0, ""));
    run_vec(mk(0, 1, 6'h2C, 0, 0, C_RD, 32'h0, "gber_absent"));
`endif

    // Asynchronous reset mid-operation drops a pending rvalid and restores outputs.
    wr = 1'b1; addr = 6'h04; wdata = 32'hFF; rd = 1'b1;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0;
    check("pre_reset_rvalid", 32'(rvalid), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rvalid", 32'(rvalid), 32'h0);
    check("async_gpio_oe", gpio_oe, 32'h0);
    check("async_gpio_out", gpio_out, 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(0, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
